// File: rtl/bram_rd_gather_pkg.sv
// Shared constants, tag type and FSM encoding for the pixel BRAM read gather.
// Build option: BRAM_OREG_EN selects the two-cycle BRAM read latency.
package bram_rd_gather_pkg;

  localparam int unsigned BUF_NUM     = 16;
  localparam int unsigned BUF_SEL_MSB = 12;
  localparam int unsigned BUF_SEL_LSB = 9;
  localparam int unsigned BUF_SEL_WD  = BUF_SEL_MSB - BUF_SEL_LSB + 1;
  localparam int unsigned LOCAL_WD    = 8;
  localparam int unsigned IDX_WD      = BUF_SEL_WD + LOCAL_WD;

`ifdef BRAM_OREG_EN
  localparam int unsigned RL = 2;
`else
  localparam int unsigned RL = 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Per-read tracking tag: valid, final-word marker and source buffer.
  typedef struct packed {
    logic                  vld;
    logic                  last;
    logic [BUF_SEL_WD-1:0] bsel;
  } rd_tag_t;

endpackage

// File: rtl/bram_rd_gather_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_WD = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_WD-1:0] wr_ptr;
  logic [PTR_WD-1:0] rd_ptr;

  // Storage, pointers and count; simultaneous push/pop keeps count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= (wr_ptr == PTR_WD'(DEPTH - 1)) ? '0 : wr_ptr + PTR_WD'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_WD'(DEPTH - 1)) ? '0 : rd_ptr + PTR_WD'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_WD'(1);
        2'b01:   count <= count - CNT_WD'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/bram_rd_gather.sv
// Walks a linear range of the 16-buffer pixel BRAM bank, issues one-hot reads
// and gathers the returned words into one valid/ready stream.
// Build option: BRAM_OREG_EN (BRAM output register, read latency 2).
module bram_rd_gather #(
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned BRAM_DATA_WD = 32,
  parameter int unsigned BUF_NUM      = 16,
  parameter int unsigned LEN_WD       = 13,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     i_start,
  input  logic [ADDR_WIDTH-1:0]                    i_base_addr,
  input  logic [LEN_WD-1:0]                        i_len,
  output logic [BUF_NUM-1:0]                       o_bram_en,
  output logic [bram_rd_gather_pkg::LOCAL_WD-1:0]  o_bram_addr,
  input  logic [BUF_NUM*BRAM_DATA_WD-1:0]          i_bram_rdata,
  output logic [BRAM_DATA_WD-1:0]                  o_data,
  output logic                                     o_valid,
  input  logic                                     i_ready,
  output logic                                     o_last,
  output logic                                     o_busy,
  output logic                                     o_done
);

  import bram_rd_gather_pkg::*;

  localparam int unsigned CNT_WD  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FIFO_WD = BRAM_DATA_WD + 1;

  state_e                state_q;
  state_e                state_d;
  logic [IDX_WD-1:0]     idx_q;
  logic [IDX_WD-1:0]     issue_idx;
  logic [LEN_WD-1:0]     rem_q;
  logic                  issue_c;
  logic                  issue_last;
  logic                  start_ok;
  logic                  start_zero;
  logic [CNT_WD-1:0]     in_flight_q;
  logic [CNT_WD-1:0]     fifo_cnt;
  logic                  credit_ok;
  rd_tag_t               tag_q [RL+1];
  logic                  push;
  logic                  pop;
  logic                  fifo_valid;
  logic                  fifo_last;
  logic [BRAM_DATA_WD-1:0] sel_data;
  logic [BRAM_DATA_WD-1:0] fifo_data;
  logic [FIFO_WD-1:0]    fifo_rdata;
  logic                  zero_done_q;
  logic                  busy_q;
  logic                  last_hs;
  logic                  unused_addr;

  assign start_ok   = i_start && (i_len != '0);
  assign start_zero = i_start && (i_len == '0);

  // Room for one more read once everything buffered or still in flight is counted.
  assign credit_ok = ({1'b0, fifo_cnt} + {1'b0, in_flight_q}) < (CNT_WD + 1)'(FIFO_DEPTH);

  assign pop     = fifo_valid && i_ready;
  assign push    = tag_q[RL].vld;
  assign last_hs = pop && fifo_last;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_RUN;
      ST_RUN:   if ((rem_q == '0) || (issue_c && (rem_q == LEN_WD'(1)))) state_d = ST_DRAIN;
      ST_DRAIN: if (last_hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Read issue decode; the first read leaves straight from IDLE using the base address.
  always_comb begin
    issue_c    = 1'b0;
    issue_idx  = idx_q;
    issue_last = (rem_q == LEN_WD'(1));
    case (state_q)
      ST_IDLE: begin
        issue_c    = start_ok;
        issue_idx  = {i_base_addr[BUF_SEL_MSB:BUF_SEL_LSB], i_base_addr[LOCAL_WD-1:0]};
        issue_last = (i_len == LEN_WD'(1));
      end
      ST_RUN:  issue_c = (rem_q != '0) && credit_ok;
      default: issue_c = 1'b0;
    endcase
  end

  // Read port drive, walking index, remaining count and status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_bram_en   <= '0;
      o_bram_addr <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      busy_q      <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      o_bram_en <= '0;
      if (issue_c) begin
        o_bram_en   <= BUF_NUM'(1) << issue_idx[IDX_WD-1:LOCAL_WD];
        o_bram_addr <= issue_idx[LOCAL_WD-1:0];
        idx_q       <= issue_idx + IDX_WD'(1);
      end
      if ((state_q == ST_IDLE) && start_ok) rem_q <= i_len - LEN_WD'(1);
      else if (issue_c)                     rem_q <= rem_q - LEN_WD'(1);
      busy_q      <= (state_d != ST_IDLE);
      zero_done_q <= (state_q == ST_IDLE) && start_zero;
    end
  end

  // Tag pipe: stage 0 mirrors the read enable, stage RL lines up with returned data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i <= RL; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= {issue_c, issue_last, issue_idx[IDX_WD-1:LOCAL_WD]};
      for (int unsigned i = 1; i <= RL; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Reads issued whose data has not yet entered the FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_flight_q <= '0;
    end else begin
      case ({issue_c, push})
        2'b10:   in_flight_q <= in_flight_q + CNT_WD'(1);
        2'b01:   in_flight_q <= in_flight_q - CNT_WD'(1);
        default: in_flight_q <= in_flight_q;
      endcase
    end
  end

  // Select the returning word from the buffer the tag points at.
  always_comb begin
    sel_data = '0;
    for (int unsigned n = 0; n < BUF_NUM; n++) begin
      if (tag_q[RL].bsel == BUF_SEL_WD'(n)) sel_data = i_bram_rdata[n*BRAM_DATA_WD +: BRAM_DATA_WD];
    end
  end

  sync_fifo_fwft #(
    .WIDTH (FIFO_WD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata ({tag_q[RL].last, sel_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .valid (fifo_valid),
    .count (fifo_cnt)
  );

  assign fifo_last = fifo_rdata[FIFO_WD-1];
  assign fifo_data = fifo_rdata[BRAM_DATA_WD-1:0];

  assign o_data  = fifo_data;
  assign o_valid = fifo_valid;
  assign o_last  = fifo_valid && fifo_last;
  assign o_busy  = busy_q;
  assign o_done  = zero_done_q || ((state_q == ST_DRAIN) && last_hs);

  assign unused_addr = ^{i_base_addr[ADDR_WIDTH-1:BUF_SEL_MSB+1], i_base_addr[LOCAL_WD]};

endmodule

// File: tb/tb_bram_rd_gather.sv
// Scoreboard bench for bram_rd_gather with a behavioural 16-buffer BRAM model.
module tb_bram_rd_gather;

  localparam int unsigned DEPTH = 4;
`ifdef BRAM_OREG_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 2;
`endif

  logic         clk;
  logic         rstn;
  logic         i_start;
  logic [13:0]  i_base_addr;
  logic [12:0]  i_len;
  logic [15:0]  o_bram_en;
  logic [7:0]   o_bram_addr;
  logic [511:0] i_bram_rdata;
  logic [31:0]  o_data;
  logic         o_valid;
  logic         i_ready;
  logic         o_last;
  logic         o_busy;
  logic         o_done;

  bram_rd_gather dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_start      (i_start),
    .i_base_addr  (i_base_addr),
    .i_len        (i_len),
    .o_bram_en    (o_bram_en),
    .o_bram_addr  (o_bram_addr),
    .i_bram_rdata (i_bram_rdata),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_last       (o_last),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Content of buffer b at local address a.
  function automatic logic [31:0] word(input logic [3:0] b, input logic [7:0] a);
    return {4'hD, b, 8'h5A, 4'h0, b, a};
  endfunction

  logic [511:0] bram_q = '0;
  always @(posedge clk)
    for (int n = 0; n < 16; n++)
      if (o_bram_en[n]) bram_q[n*32 +: 32] <= word(4'(n), o_bram_addr);
`ifdef BRAM_OREG_EN
  logic [511:0] oreg_q = '0;
  always @(posedge clk) oreg_q <= bram_q;
  assign i_bram_rdata = oreg_q;
`else
  assign i_bram_rdata = bram_q;
`endif

  logic [23:0] exp_rd [$];
  logic [32:0] exp_wd [$];
  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int lat = -1;
  int cyc = 0;
  bit seen_valid = 0;
  bit busy_prev = 0;
  logic [23:0] e_rd;
  logic [32:0] e_wd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every read issue and every stream handshake against the queues.
  always @(negedge clk) begin
    if (!rstn) begin
      busy_prev = 1'b0;
    end else begin
      if (o_bram_en != '0) begin
        rd_cnt++;
        if (exp_rd.size() == 0) chk("rd_unexpected", 64'({o_bram_en, o_bram_addr}), 64'd0);
        else begin
          e_rd = exp_rd.pop_front();
          chk("rd_en_addr", 64'({o_bram_en, o_bram_addr}), 64'(e_rd));
        end
      end
      if (o_valid && i_ready) begin
        if (exp_wd.size() == 0) chk("word_unexpected", 64'({o_last, o_data}), 64'd0);
        else begin
          e_wd = exp_wd.pop_front();
          chk("stream_word", 64'({o_last, o_data}), 64'(e_wd));
          chk("done_on_last", 64'(o_done), 64'(e_wd[32]));
        end
      end
      if (o_done) done_cnt++;
      if (o_busy && !busy_prev) begin
        cyc = 0;
        seen_valid = 1'b0;
      end else begin
        cyc++;
      end
      if (o_busy && o_valid && !seen_valid) begin
        seen_valid = 1'b1;
        lat = cyc;
      end
      busy_prev = o_busy;
    end
  end

  task automatic push_exp(input logic [23:0] rd, input logic [32:0] wd);
    exp_rd.push_back(rd);
    exp_wd.push_back(wd);
  endtask

  task automatic gen_exp(input logic [13:0] base, input int len);
    logic [11:0] idx;
    idx = {base[12:9], base[7:0]};
    for (int i = 0; i < len; i++) begin
      push_exp({16'(1) << idx[11:8], idx[7:0]}, {(i == len - 1), word(idx[11:8], idx[7:0])});
      idx = idx + 12'd1;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_en"},    64'(o_bram_en),   64'd0);
    chk({tag, "_addr"},  64'(o_bram_addr), 64'd0);
    chk({tag, "_valid"}, 64'(o_valid),     64'd0);
    chk({tag, "_data"},  64'(o_data),      64'd0);
    chk({tag, "_last"},  64'(o_last),      64'd0);
    chk({tag, "_busy"},  64'(o_busy),      64'd0);
    chk({tag, "_done"},  64'(o_done),      64'd0);
  endtask

  task automatic run_xfer(input logic [13:0] base, input logic [12:0] len, input int stall);
    int d0;
    bit ok;
    d0 = done_cnt;
    rd_cnt = 0;
    @(posedge clk); #1;
    i_start = 1'b1;
    i_base_addr = base;
    i_len = len;
    if (stall > 0) i_ready = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk); #1;
    chk("busy_rise", 64'(o_busy), 64'd1);
    if (stall > 0) begin
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
        if (o_valid) ok = 1'b1;
        else begin @(negedge clk); #1; end
      end
      chk("stall_first_valid", 64'(ok), 64'd1);
      repeat (stall) @(negedge clk);
      #1;
      chk("stall_outstanding", 64'(rd_cnt), 64'(DEPTH));
      @(posedge clk); #1;
      i_ready = 1'b1;
    end
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) ok = 1'b1;
    end
    chk("done_timeout", 64'(ok), 64'd1);
    chk("done_count", 64'(done_cnt - d0), 64'd1);
    @(negedge clk); #1;
    chk("busy_fall", 64'(o_busy), 64'd0);
    chk("first_valid_lat", 64'(lat), 64'(EXP_LAT));
    chk("rd_total", 64'(rd_cnt), 64'(len));
  endtask

  initial begin
    int d0;
    rstn = 1'b0;
    i_start = 1'b0;
    i_base_addr = '0;
    i_len = '0;
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rstn = 1'b1;

    // buf0, local 0..3
    push_exp(24'h000100, {1'b0, 32'hD05A0000});
    push_exp(24'h000101, {1'b0, 32'hD05A0001});
    push_exp(24'h000102, {1'b0, 32'hD05A0002});
    push_exp(24'h000103, {1'b1, 32'hD05A0003});
    run_xfer(14'h0000, 13'd4, 0);

    // buf15/0xFE wraps to buf0/0x00
    push_exp(24'h8000FE, {1'b0, 32'hDF5A0FFE});
    push_exp(24'h8000FF, {1'b0, 32'hDF5A0FFF});
    push_exp(24'h000100, {1'b0, 32'hD05A0000});
    push_exp(24'h000101, {1'b1, 32'hD05A0001});
    run_xfer(14'h1EFE, 13'd4, 0);

    // buf1/0xFF rolls into buf2/0x00
    push_exp(24'h0002FF, {1'b0, 32'hD15A01FF});
    push_exp(24'h000400, {1'b1, 32'hD25A0200});
    run_xfer(14'h02FF, 13'd2, 0);

    // back-pressure: issue must stop at FIFO_DEPTH outstanding words
    gen_exp(14'h0010, 8);
    run_xfer(14'h0010, 13'd8, 6);

    // zero-length start
    rd_cnt = 0;
    @(posedge clk); #1;
    i_start = 1'b1;
    i_base_addr = 14'h0123;
    i_len = '0;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk); #1;
    chk("zero_done", 64'(o_done), 64'd1);
    chk("zero_busy", 64'(o_busy), 64'd0);
    @(negedge clk); #1;
    chk("zero_done_pulse", 64'(o_done), 64'd0);
    chk("zero_busy_after", 64'(o_busy), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("zero_no_reads", 64'(rd_cnt), 64'd0);

    // reset in the middle of a long transfer, then a short clean one
    gen_exp(14'h0A00, 16);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_base_addr = 14'h0A00;
    i_len = 13'd16;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_idle_outputs("midreset");
    exp_rd.delete();
    exp_wd.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("no_done_in_reset", 64'(done_cnt - d0), 64'd0);
    gen_exp(14'h0404, 2);
    run_xfer(14'h0404, 13'd2, 0);
    chk("done_after_reset", 64'(done_cnt - d0), 64'd1);

    repeat (4) @(negedge clk);
    #1;
    chk("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
    chk("word_queue_empty", 64'(exp_wd.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1);
  end

endmodule
